// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode encodings and the
// request-control bundle that travels through the first pipeline stage.
package alu_pkg;

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  // Control fields of a captured request; the width-dependent operands
  // are held next to it in the stage-1 registers.
  typedef struct packed {
    logic [2:0] oper;
    logic       cin;
    logic       inv_a;
    logic       inv_b;
    logic       sign;
    logic       acc;
  } s1_req_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: operand inversion, the eight
// operations, zero detect and the overflow rule for add.
module alu_core
  import alu_pkg::*;
#(
  parameter int OPERAND_WIDTH = 16,
  parameter int SHAMT_WIDTH   = $clog2(OPERAND_WIDTH)
) (
  input  logic [OPERAND_WIDTH-1:0] a,
  input  logic [OPERAND_WIDTH-1:0] b,
  input  logic                     cin,
  input  logic [2:0]               oper,
  input  logic                     inv_a,
  input  logic                     inv_b,
  input  logic                     sign,
  output logic [OPERAND_WIDTH-1:0] result,
  output logic                     zero,
  output logic                     ofl
);

  localparam logic [SHAMT_WIDTH:0] W_EXT = (SHAMT_WIDTH+1)'(OPERAND_WIDTH);

  logic [OPERAND_WIDTH-1:0] op_a;
  logic [OPERAND_WIDTH-1:0] op_b;
  logic [SHAMT_WIDTH-1:0]   shamt;
  logic [SHAMT_WIDTH:0]     rot_back;
  logic [OPERAND_WIDTH:0]   sum;

  // Select the operation; a rotate by 0 shifts the wrap-around part out
  // entirely (shift by full width gives 0), so A passes unchanged.
  always_comb begin
    op_a     = inv_a ? ~a : a;
    op_b     = inv_b ? ~b : b;
    shamt    = op_b[SHAMT_WIDTH-1:0];
    rot_back = W_EXT - {1'b0, shamt};
    sum      = {1'b0, op_a} + {1'b0, op_b} + {{OPERAND_WIDTH{1'b0}}, cin};
    result   = '0;
    ofl      = 1'b0;
    case (oper)
      OP_ROL: result = (op_a << shamt) | (op_a >> rot_back);
      OP_SLL: result = op_a << shamt;
      OP_SRA: result = $signed(op_a) >>> shamt;
      OP_SRL: result = op_a >> shamt;
      OP_ADD: begin
        result = sum[OPERAND_WIDTH-1:0];
        if (sign)
          ofl = (op_a[OPERAND_WIDTH-1] == op_b[OPERAND_WIDTH-1]) &&
                (sum[OPERAND_WIDTH-1] != op_a[OPERAND_WIDTH-1]);
        else
          ofl = sum[OPERAND_WIDTH];
      end
      OP_AND: result = op_a & op_b;
      OP_OR:  result = op_a | op_b;
      OP_XOR: result = op_a ^ op_b;
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline. S1 captures the request, the
// compute happens on the S1->S2 transfer, S2 presents the result.
// Also keeps the accumulator (last result) and a sticky overflow flag.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int OPERAND_WIDTH  = 16,
  parameter int NUM_OPERATIONS = 3,
  parameter int SHAMT_WIDTH    = $clog2(OPERAND_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OPERAND_WIDTH-1:0]  InA,
  input  logic [OPERAND_WIDTH-1:0]  InB,
  input  logic                      Cin,
  input  logic [NUM_OPERATIONS-1:0] Oper,
  input  logic                      invA,
  input  logic                      invB,
  input  logic                      sign,
  input  logic                      acc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OPERAND_WIDTH-1:0]  Out,
  output logic                      Zero,
  output logic                      Ofl,
  output logic                      ofl_sticky,
  input  logic                      clr_ofl
);

  // Handshake: a transfer happens on a rising edge where valid & ready are
  // both high. Once valid is raised the payload is held until that edge.
  // in_ready depends only on pipeline state and out_ready, never on in_valid.

  logic                     s1_valid;
  logic [OPERAND_WIDTH-1:0] s1_a;
  logic [OPERAND_WIDTH-1:0] s1_b;
  s1_req_t                  s1_req;
  logic                     s2_valid;
  logic [OPERAND_WIDTH-1:0] acc_q;
  logic                     s1_adv;
  logic                     s2_adv;
  logic [OPERAND_WIDTH-1:0] core_a;
  logic [OPERAND_WIDTH-1:0] core_res;
  logic                     core_zero;
  logic                     core_ofl;

  // Stage advance conditions and operand-A source selection
  always_comb begin
    s2_adv   = !s2_valid || out_ready;
    s1_adv   = s1_valid && s2_adv;
    in_ready = !s1_valid || s2_adv;
    core_a   = s1_req.acc ? acc_q : s1_a;
  end

  assign out_valid = s2_valid;

  alu_core #(
    .OPERAND_WIDTH (OPERAND_WIDTH),
    .SHAMT_WIDTH   (SHAMT_WIDTH)
  ) u_core (
    .a      (core_a),
    .b      (s1_b),
    .cin    (s1_req.cin),
    .oper   (s1_req.oper),
    .inv_a  (s1_req.inv_a),
    .inv_b  (s1_req.inv_b),
    .sign   (s1_req.sign),
    .result (core_res),
    .zero   (core_zero),
    .ofl    (core_ofl)
  );

  // Stage 1: capture an accepted request, empty when it moves on
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_req   <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_a     <= InA;
      s1_b     <= InB;
      s1_req   <= '{oper: Oper, cin: Cin, inv_a: invA, inv_b: invB,
                    sign: sign, acc: acc};
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: load the computed result, hold it while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      Out      <= '0;
      Zero     <= 1'b0;
      Ofl      <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      Out      <= core_res;
      Zero     <= core_zero;
      Ofl      <= core_ofl;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  // Accumulator follows every result so back-to-back acc ops chain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        acc_q <= '0;
    else if (s1_adv) acc_q <= core_res;
  end

  // Sticky overflow; a new overflow beats a simultaneous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     ofl_sticky <= 1'b0;
    else if (s1_adv && core_ofl)  ofl_sticky <= 1'b1;
    else if (clr_ofl)             ofl_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed cases from the datasheet plus a randomized
// stream, checked through an expected-result queue.
module tb_alu_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] InA = '0;
  logic [W-1:0] InB = '0;
  logic         Cin = 1'b0;
  logic [2:0]   Oper = '0;
  logic         invA = 1'b0;
  logic         invB = 1'b0;
  logic         sign = 1'b0;
  logic         acc = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] Out;
  logic         Zero;
  logic         Ofl;
  logic         ofl_sticky;
  logic         clr_ofl = 1'b0;

  int checks = 0;
  int failures = 0;

  // {ofl, zero, out}
  logic [W+1:0] exp_q[$];
  logic [W-1:0] model_acc = '0;
  logic         forced_ready = 1'b1;
  logic         rand_bp = 1'b0;

  alu_pipe #(.OPERAND_WIDTH(W), .NUM_OPERATIONS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .InA(InA), .InB(InB), .Cin(Cin), .Oper(Oper), .invA(invA), .invB(invB),
    .sign(sign), .acc(acc), .out_valid(out_valid), .out_ready(out_ready),
    .Out(Out), .Zero(Zero), .Ofl(Ofl), .ofl_sticky(ofl_sticky),
    .clr_ofl(clr_ofl)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  // Sole writer of out_ready: random backpressure or a directed level
  always @(posedge clk) begin
    #2;
    out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : forced_ready;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: arithmetic on plain integers, returns {ofl, result}
  function automatic logic [W:0] ref_op(
    input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
    input logic [2:0] op, input logic ia, input logic ib, input logic sg,
    input logic ac, input logic [W-1:0] accv);
    int unsigned av, bv, s, r, sum;
    int sa, sb, ss;
    logic o;
    av = ac ? accv : a;
    bv = b;
    if (ia) av = av ^ 32'hFFFF;
    if (ib) bv = bv ^ 32'hFFFF;
    s = bv % W;
    o = 1'b0;
    r = 0;
    case (op)
      3'd0: r = ((av << s) | (av >> (W - s))) & 32'hFFFF;
      3'd1: r = (av << s) & 32'hFFFF;
      3'd2: r = (av >= 32768) ? ((av >> s) | ((32'hFFFF << (W - s)) & 32'hFFFF))
                              : (av >> s);
      3'd3: r = av >> s;
      3'd4: begin
        sum = av + bv + c;
        r = sum & 32'hFFFF;
        if (sg) begin
          sa = (av >= 32768) ? int'(av) - 65536 : int'(av);
          sb = (bv >= 32768) ? int'(bv) - 65536 : int'(bv);
          ss = sa + sb + int'(c);
          o = (ss > 32767) || (ss < -32768);
        end else begin
          o = (sum > 32'hFFFF);
        end
      end
      3'd5: r = av & bv;
      3'd6: r = av | bv;
      default: r = av ^ bv;
    endcase
    return {o, r[W-1:0]};
  endfunction

  // Driver: offer one op, push its expectation at the accepting edge.
  // in_valid stays high on return so consecutive calls stream.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] op, input logic c, input logic ia,
                      input logic ib, input logic sg, input logic ac,
                      input logic use_exp, input logic [W-1:0] e_out,
                      input logic e_ofl);
    logic [W:0] m;
    logic [W-1:0] r;
    logic o;
    bit done;
    InA = a; InB = b; Oper = op; Cin = c; invA = ia; invB = ib;
    sign = sg; acc = ac; in_valid = 1'b1;
    m = ref_op(a, b, c, op, ia, ib, sg, ac, model_acc);
    r = use_exp ? e_out : m[W-1:0];
    o = use_exp ? e_ofl : m[W];
    done = 0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({o, (r == '0), r});
        model_acc = r;
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=accept");
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int t = 0; t < 1000 && exp_q.size() != 0; t++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: whenever a result is shown it must match the head
  // of the queue (every stalled cycle too); pop it when it is consumed.
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0h required=none", Out);
      end else begin
        e = exp_q[0];
        if (out_ready) begin
          check("result", {Ofl, Zero, Out}, e);
          void'(exp_q.pop_front());
        end else begin
          check("stall_hold", {Ofl, Zero, Out}, e);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out", {Ofl, Zero, Out}, 0);
    check("rst_sticky", ofl_sticky, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Signed / unsigned add overflow
    send(16'h7FFF, 16'h0001, 3'd4, 0, 0, 0, 1, 0, 1, 16'h8000, 1);
    send(16'h7FFF, 16'h0001, 3'd4, 0, 0, 0, 0, 0, 1, 16'h8000, 0);
    send(16'hFFFF, 16'h0001, 3'd4, 0, 0, 0, 0, 0, 1, 16'h0000, 1);
    drain();
    check("sticky_after_ofl", ofl_sticky, 1);

    // Shifts and rotates, including a zero shift amount
    send(16'h8001, 16'd1,  3'd0, 0, 0, 0, 0, 0, 1, 16'h0003, 0);
    send(16'h8000, 16'd4,  3'd2, 0, 0, 0, 0, 0, 1, 16'hF800, 0);
    send(16'h8000, 16'd4,  3'd3, 0, 0, 0, 0, 0, 1, 16'h0800, 0);
    send(16'h0001, 16'd15, 3'd1, 0, 0, 0, 0, 0, 1, 16'h8000, 0);
    send(16'h1234, 16'd0,  3'd0, 0, 0, 0, 0, 0, 1, 16'h1234, 0);
    send(16'h1234, 16'hFFFF, 3'd2, 0, 0, 1, 0, 0, 1, 16'h1234, 0);
    drain();

    // Sticky clear, then clear coinciding with a new overflow
    clr_ofl = 1'b1;
    @(posedge clk);
    #1;
    clr_ofl = 1'b0;
    @(negedge clk);
    check("sticky_cleared", ofl_sticky, 0);
    @(posedge clk);
    #1;
    send(16'h7FFF, 16'h0001, 3'd4, 0, 0, 0, 1, 0, 1, 16'h8000, 1);
    in_valid = 1'b0;
    clr_ofl = 1'b1;
    @(posedge clk);
    #1;
    clr_ofl = 1'b0;
    @(negedge clk);
    check("sticky_set_wins", ofl_sticky, 1);
    drain();

    // Accumulate chain
    send(16'd5,    16'd3,      3'd4, 0, 0, 0, 0, 0, 1, 16'd8,  0);
    send(16'hDEAD, 16'd2,      3'd4, 0, 0, 0, 0, 1, 1, 16'd10, 0);
    send(16'hBEEF, 16'h000A,   3'd7, 0, 0, 0, 0, 1, 1, 16'd0,  0);
    drain();

    // Backpressure mid-stream
    forced_ready = 1'b1;
    send(16'($urandom), 16'($urandom), 3'd5, 0, 0, 0, 0, 0, 0, '0, 0);
    forced_ready = 1'b0;
    send(16'($urandom), 16'($urandom), 3'd6, 0, 0, 0, 0, 0, 0, '0, 0);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    idle(2);
    forced_ready = 1'b1;
    send(16'($urandom), 16'($urandom), 3'd4, 1, 0, 0, 1, 0, 0, '0, 0);
    send(16'($urandom), 16'($urandom), 3'd7, 0, 1, 0, 0, 1, 0, '0, 0);
    drain();

    // Randomized stream with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 17)) : 16'($urandom);
      send(ra, rb, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom_range(0, 2) == 0),
           0, '0, 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    drain();
    rand_bp = 1'b0;
    forced_ready = 1'b1;
    idle(2);

    // Reset while full and stalled
    forced_ready = 1'b0;
    send(16'h7FFF, 16'h0001, 3'd4, 0, 0, 0, 1, 0, 1, 16'h8000, 1);
    send(16'h0F0F, 16'h00FF, 3'd5, 0, 0, 0, 0, 0, 1, 16'h000F, 0);
    in_valid = 1'b0;
    @(negedge clk);
    check("full_in_ready_low", in_ready, 0);
    check("full_sticky", ofl_sticky, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_sticky", ofl_sticky, 0);
    check("async_rst_out", {Ofl, Zero, Out}, 0);
    exp_q.delete();
    model_acc = '0;
    forced_ready = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    // acc_q was cleared, so acc + 7 gives 7
    send(16'h5555, 16'd7, 3'd4, 0, 0, 0, 0, 1, 1, 16'd7, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
